// File: rtl/jlc3_uart_tx_pkg.sv
// Shared definitions for the jlc3 UART transmitter: FSM encodings, status bit indices, divider floor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package jlc3_uart_tx_pkg;

  typedef enum logic [2:0] {
    UART_TX_IDLE   = 3'd0,
    UART_TX_START  = 3'd1,
    UART_TX_DATA   = 3'd2,
    UART_TX_PARITY = 3'd3,
    UART_TX_STOP   = 3'd4
  } uart_tx_state_e;

  // Bit positions inside sta_o_r
  localparam int UART_STA_FULL = 0;
  localparam int UART_STA_IDLE = 1;

  // Smallest usable clocks-per-bit; the bit timer needs at least two states
  localparam logic [15:0] UART_DIV_MIN = 16'd2;

  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < UART_DIV_MIN) ? UART_DIV_MIN : d;
  endfunction

endpackage

// File: rtl/jlc3_uart_tx_if.sv
// Register-side bus of the UART transmitter (memory controller <-> jlc3_uart_tx).
// Latency: n/a (wiring only); master = memory controller, slave = transmitter.
// Backpressure: none on the wire; a push into a full FIFO is dropped and flagged via ovf_o_r.
// Signals: en/send/schar/div_wr/div/clr (+ par_odd when JLC3_UART_TX_PARITY_EN is defined)
//          flow master->slave; sta/level/ovf/txd flow slave->master.
interface jlc3_uart_tx_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              en_i_w;
  logic              send_i_w;
  logic [DATA_W-1:0] schar_i_w;
  logic              div_wr_i_w;
  logic [15:0]       div_i_w;
  logic              clr_i_w;
`ifdef JLC3_UART_TX_PARITY_EN
  logic              par_odd_i_w;
`endif
  logic [1:0]        sta_o_r;
  logic [LVL_W-1:0]  level_o_r;
  logic              ovf_o_r;
  logic              txd_o_r;

`ifdef JLC3_UART_TX_PARITY_EN
  modport master (
    output en_i_w, send_i_w, schar_i_w, div_wr_i_w, div_i_w, clr_i_w, par_odd_i_w,
    input  sta_o_r, level_o_r, ovf_o_r, txd_o_r
  );
  modport slave (
    input  en_i_w, send_i_w, schar_i_w, div_wr_i_w, div_i_w, clr_i_w, par_odd_i_w,
    output sta_o_r, level_o_r, ovf_o_r, txd_o_r
  );
`else
  modport master (
    output en_i_w, send_i_w, schar_i_w, div_wr_i_w, div_i_w, clr_i_w,
    input  sta_o_r, level_o_r, ovf_o_r, txd_o_r
  );
  modport slave (
    input  en_i_w, send_i_w, schar_i_w, div_wr_i_w, div_i_w, clr_i_w,
    output sta_o_r, level_o_r, ovf_o_r, txd_o_r
  );
`endif

endinterface

// File: rtl/jlc3_uart_tx_sync_fifo.sv
// Generic synchronous FIFO, first-word-fall-through read port.
// Latency: a push is visible at rd_dat/empty/level the cycle after it is accepted.
// Backpressure: push ignored while full, pop ignored while empty (both judged on start-of-cycle state).
// Ports: clk_i_w, rst_i_w (async, active-low), push/wr_dat, pop/rd_dat, full, empty, level.
module jlc3_uart_tx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i_w,
  input  logic                   rst_i_w,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra MSB so full (MSBs differ) and empty (equal) are distinct
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign level   = wr_ptr_r - rd_ptr_r;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_dat  = mem_r[rd_ptr_r[AW-1:0]];

  always_ff @(posedge clk_i_w or negedge rst_i_w) begin
    if (!rst_i_w) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_ok)  rd_ptr_r <= rd_ptr_r + 1'b1;
    end
  end

  // Storage is not reset: contents are meaningless once the pointers are cleared
  always_ff @(posedge clk_i_w) begin
    if (push_ok) mem_r[wr_ptr_r[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/jlc3_uart_tx.sv
// Buffered UART transmitter: FIFO-fed, LSB-first serialiser with run-time baud divider.
// Latency: a char pushed into an empty idle FIFO drives the start bit two cycles after the push cycle.
// Backpressure: none; pushes while full are dropped and latch ovf_o_r until clr_i_w.
// Ports: clk_i_w, rst_i_w (async, active-low), bus (jlc3_uart_tx_if.slave).
// Optional: define JLC3_UART_TX_PARITY_EN for a parity bit after the data bits (par_odd_i_w selects odd).
module jlc3_uart_tx
  import jlc3_uart_tx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic           clk_i_w,
  input  logic           rst_i_w,
  jlc3_uart_tx_if.slave  bus
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_e    state_r, state_nxt;
  logic [15:0]       div_sh_r;
  logic [15:0]       div_act_r, div_act_nxt;
  logic [15:0]       tmr_r, tmr_nxt;
  logic [3:0]        bcnt_r, bcnt_nxt;
  logic [DATA_W-1:0] shreg_r, shreg_nxt;
  logic              txd_nxt;
  logic              bit_end;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [LVL_W-1:0]  fifo_level;
`ifdef JLC3_UART_TX_PARITY_EN
  logic              par_r;
`endif

  jlc3_uart_tx_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i_w (clk_i_w),
    .rst_i_w (rst_i_w),
    .push    (bus.send_i_w),
    .wr_dat  (bus.schar_i_w),
    .pop     (pop),
    .rd_dat  (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign bus.level_o_r = fifo_level;
  assign bit_end       = (tmr_r == div_act_r - 16'd1);

  // Next-state / datapath control
  always_comb begin
    state_nxt   = state_r;
    tmr_nxt     = tmr_r + 16'd1;
    bcnt_nxt    = bcnt_r;
    shreg_nxt   = shreg_r;
    div_act_nxt = div_act_r;
    pop         = 1'b0;

    unique case (state_r)
      UART_TX_IDLE: begin
        tmr_nxt = '0;
        if (bus.en_i_w && !fifo_empty) pop = 1'b1;
      end
      UART_TX_START: begin
        if (bit_end) begin
          state_nxt = UART_TX_DATA;
          tmr_nxt   = '0;
          bcnt_nxt  = '0;
        end
      end
      UART_TX_DATA: begin
        if (bit_end) begin
          tmr_nxt = '0;
          if (bcnt_r == 4'(DATA_W - 1)) begin
`ifdef JLC3_UART_TX_PARITY_EN
            state_nxt = UART_TX_PARITY;
`else
            state_nxt = UART_TX_STOP;
`endif
            bcnt_nxt  = '0;
          end else begin
            bcnt_nxt  = bcnt_r + 4'd1;
            shreg_nxt = {1'b0, shreg_r[DATA_W-1:1]};
          end
        end
      end
`ifdef JLC3_UART_TX_PARITY_EN
      UART_TX_PARITY: begin
        if (bit_end) begin
          state_nxt = UART_TX_STOP;
          tmr_nxt   = '0;
          bcnt_nxt  = '0;
        end
      end
`endif
      UART_TX_STOP: begin
        if (bit_end) begin
          tmr_nxt = '0;
          if (bcnt_r == 4'(STOP_BITS - 1)) begin
            // Chain straight into the next start bit when more data is waiting
            if (bus.en_i_w && !fifo_empty) pop = 1'b1;
            else                           state_nxt = UART_TX_IDLE;
          end else begin
            bcnt_nxt = bcnt_r + 4'd1;
          end
        end
      end
      default: begin
        state_nxt = UART_TX_IDLE;
        tmr_nxt   = '0;
      end
    endcase

    // Frame launch: rate is frozen here so a divider write never splits a frame
    if (pop) begin
      state_nxt   = UART_TX_START;
      tmr_nxt     = '0;
      bcnt_nxt    = '0;
      shreg_nxt   = fifo_head;
      div_act_nxt = div_sh_r;
    end
  end

  // Line level is registered from the next state so txd never glitches
  always_comb begin
    txd_nxt = 1'b1;
    unique case (state_nxt)
      UART_TX_START:  txd_nxt = 1'b0;
      UART_TX_DATA:   txd_nxt = shreg_nxt[0];
`ifdef JLC3_UART_TX_PARITY_EN
      UART_TX_PARITY: txd_nxt = par_r;
`endif
      default:        txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i_w or negedge rst_i_w) begin
    if (!rst_i_w) begin
      state_r     <= UART_TX_IDLE;
      tmr_r       <= '0;
      bcnt_r      <= '0;
      shreg_r     <= '0;
      div_act_r   <= 16'(CLK_DIV);
      bus.txd_o_r <= 1'b1;
    end else begin
      state_r     <= state_nxt;
      tmr_r       <= tmr_nxt;
      bcnt_r      <= bcnt_nxt;
      shreg_r     <= shreg_nxt;
      div_act_r   <= div_act_nxt;
      bus.txd_o_r <= txd_nxt;
    end
  end

`ifdef JLC3_UART_TX_PARITY_EN
  // Parity is fixed when the char is popped; par_odd_i_w flips even to odd
  always_ff @(posedge clk_i_w or negedge rst_i_w) begin
    if (!rst_i_w)  par_r <= 1'b0;
    else if (pop)  par_r <= (^fifo_head) ^ bus.par_odd_i_w;
  end
`endif

  // Divider shadow, sticky overflow and status
  always_ff @(posedge clk_i_w or negedge rst_i_w) begin
    if (!rst_i_w) begin
      div_sh_r                   <= 16'(CLK_DIV);
      bus.ovf_o_r                <= 1'b0;
      bus.sta_o_r[UART_STA_FULL] <= 1'b0;
      bus.sta_o_r[UART_STA_IDLE] <= 1'b1;
    end else begin
      if (bus.div_wr_i_w) div_sh_r <= clamp_div(bus.div_i_w);
      // A rejected push outranks a clear in the same cycle
      if (bus.send_i_w && fifo_full) bus.ovf_o_r <= 1'b1;
      else if (bus.clr_i_w)          bus.ovf_o_r <= 1'b0;
      bus.sta_o_r[UART_STA_FULL] <= fifo_full;
      bus.sta_o_r[UART_STA_IDLE] <= fifo_empty && (state_r == UART_TX_IDLE);
    end
  end

endmodule

// File: tb/tb_jlc3_uart_tx.sv
// Self-checking bench for jlc3_uart_tx: directed vectors plus cycle-exact frame waveform checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_jlc3_uart_tx;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int CLK_DIV    = 16;
  localparam int STOP_BITS  = 1;

  logic clk;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  jlc3_uart_tx_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  jlc3_uart_tx #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CLK_DIV    (CLK_DIV),
    .STOP_BITS  (STOP_BITS)
  ) dut (
    .clk_i_w (clk),
    .rst_i_w (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       send;
    logic [7:0] schar;
    logic       clr;
    logic [3:0] exp_level;
    logic [1:0] exp_sta;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] c);
    bus.send_i_w  = 1'b1;
    bus.schar_i_w = c;
    tick();
    bus.send_i_w  = 1'b0;
  endtask

  task automatic wait_low(input string nm, input int budget);
    int n;
    n = 0;
    while (bus.txd_o_r !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk(nm, 32'(bus.txd_o_r), 32'd0);
  endtask

  // Entered on the first sample showing the start bit; checks every cycle of the frame.
  // par < 0 means no parity bit. A divider write can be injected at frame cycle wr_k.
  task automatic expect_frame(input string nm, input logic [7:0] ch, input int div,
                              input int par, input int wr_k, input logic [15:0] wr_val);
    int   nb;
    int   b;
    int   errs;
    int   first_bad;
    logic e;
    nb        = 1 + DATA_W + STOP_BITS + ((par >= 0) ? 1 : 0);
    errs      = 0;
    first_bad = -1;
    for (int k = 0; k < nb * div; k++) begin
      b = k / div;
      if (b == 0)                           e = 1'b0;
      else if (b <= DATA_W)                 e = ch[b-1];
      else if (par >= 0 && b == DATA_W + 1) e = par[0];
      else                                  e = 1'b1;
      if (bus.txd_o_r !== e) begin
        errs++;
        if (first_bad < 0) first_bad = k;
      end
      if (k == wr_k) begin
        bus.div_wr_i_w = 1'b1;
        bus.div_i_w    = wr_val;
      end else begin
        bus.div_wr_i_w = 1'b0;
      end
      tick();
    end
    bus.div_wr_i_w = 1'b0;
    n_cmp++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL %s: got %0d wrong bit-cycles (first at %0d), want 0", nm, errs, first_bad);
    end
  endtask

  // Line must stay high and the FIFO empty for the whole window
  task automatic hold_idle(input string nm, input int cycles);
    int bad;
    bad = 0;
    for (int k = 0; k < cycles; k++) begin
      if (bus.txd_o_r !== 1'b1 || bus.level_o_r !== 4'd0) bad++;
      tick();
    end
    chk(nm, 32'(bad), 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.en_i_w     = 1'b1;
    bus.send_i_w   = 1'b0;
    bus.schar_i_w  = '0;
    bus.div_wr_i_w = 1'b0;
    bus.div_i_w    = '0;
    bus.clr_i_w    = 1'b0;
`ifdef JLC3_UART_TX_PARITY_EN
    bus.par_odd_i_w = 1'b0;
`endif

    // Fill-to-overflow table: sta lags one cycle behind the FIFO state
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 8'(8'h31 + i), 1'b0, 4'(i + 1), (i == 0) ? 2'b10 : 2'b00, 1'b0};
    vecs[8]  = '{1'b1, 8'h39, 1'b0, 4'd8, 2'b01, 1'b1};
    vecs[9]  = '{1'b1, 8'h3a, 1'b0, 4'd8, 2'b01, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 4'd8, 2'b01, 1'b0};
    vecs[11] = '{1'b1, 8'h3b, 1'b1, 4'd8, 2'b01, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 4'd8, 2'b01, 1'b0};

    // Reset values
    tick();
    tick();
    chk("rst_txd",   32'(bus.txd_o_r),   32'd1);
    chk("rst_sta",   32'(bus.sta_o_r),   32'h2);
    chk("rst_level", 32'(bus.level_o_r), 32'd0);
    chk("rst_ovf",   32'(bus.ovf_o_r),   32'd0);
    rst_n = 1'b1;
    tick();

    // Single char 0x55 at the reset divider
    push(8'h55);
    chk("t1_level_after_push", 32'(bus.level_o_r), 32'd1);
    chk("t1_txd_before_start", 32'(bus.txd_o_r),   32'd1);
    tick();
    wait_low("t1_start", 4);
    expect_frame("t1_frame_55", 8'h55, 16, -1, -1, 16'd0);
    tick();
    chk("t1_sta_idle", 32'(bus.sta_o_r), 32'h2);

    // Three queued chars: contiguous frames, level drops at each pop
    bus.en_i_w = 1'b0;
    push(8'h41);
    push(8'h42);
    push(8'h43);
    chk("t2_level3", 32'(bus.level_o_r), 32'd3);
    bus.en_i_w = 1'b1;
    tick();
    wait_low("t2_start", 2);
    chk("t2_level2", 32'(bus.level_o_r), 32'd2);
    expect_frame("t2_frame_41", 8'h41, 16, -1, -1, 16'd0);
    chk("t2_level1", 32'(bus.level_o_r), 32'd1);
    expect_frame("t2_frame_42", 8'h42, 16, -1, -1, 16'd0);
    chk("t2_level0", 32'(bus.level_o_r), 32'd0);
    expect_frame("t2_frame_43", 8'h43, 16, -1, -1, 16'd0);
    tick();
    chk("t2_sta_idle", 32'(bus.sta_o_r), 32'h2);

    // Overflow with the line stalled
    bus.en_i_w = 1'b0;
    for (int i = 0; i < 13; i++) begin
      bus.send_i_w  = vecs[i].send;
      bus.schar_i_w = vecs[i].schar;
      bus.clr_i_w   = vecs[i].clr;
      tick();
      chk($sformatf("t3_v%0d_level", i), 32'(bus.level_o_r), 32'(vecs[i].exp_level));
      chk($sformatf("t3_v%0d_sta",   i), 32'(bus.sta_o_r),   32'(vecs[i].exp_sta));
      chk($sformatf("t3_v%0d_ovf",   i), 32'(bus.ovf_o_r),   32'(vecs[i].exp_ovf));
    end
    bus.send_i_w = 1'b0;
    bus.clr_i_w  = 1'b0;
    bus.en_i_w   = 1'b1;
    tick();
    wait_low("t3_start", 2);
    for (int i = 0; i < 8; i++)
      expect_frame($sformatf("t3_frame_%0d", i), 8'(8'h31 + i), 16, -1, -1, 16'd0);
    hold_idle("t3_no_dropped_chars", 200);
    chk("t3_sta_idle", 32'(bus.sta_o_r), 32'h2);

    // Divider written mid-frame takes effect on the next frame only
    bus.en_i_w = 1'b0;
    push(8'ha5);
    push(8'h5a);
    bus.en_i_w = 1'b1;
    tick();
    wait_low("t4_start", 2);
    expect_frame("t4_frame_div16", 8'ha5, 16, -1, 40, 16'd4);
    expect_frame("t4_frame_div4",  8'h5a, 4,  -1, -1, 16'd0);
    tick();
    bus.div_wr_i_w = 1'b1;
    bus.div_i_w    = 16'd0;
    tick();
    bus.div_wr_i_w = 1'b0;
    push(8'h3c);
    wait_low("t4_start_div0", 4);
    expect_frame("t4_frame_div0_clamped", 8'h3c, 2, -1, -1, 16'd0);
    tick();

    // Reset in the middle of a frame with chars still queued
    bus.div_wr_i_w = 1'b1;
    bus.div_i_w    = 16'd16;
    tick();
    bus.div_wr_i_w = 1'b0;
    bus.en_i_w     = 1'b0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    bus.en_i_w = 1'b1;
    tick();
    wait_low("t5_start", 2);
    for (int k = 0; k < 70; k++) begin
      bus.div_wr_i_w = (k == 30);
      bus.div_i_w    = 16'd4;
      tick();
    end
    bus.div_wr_i_w = 1'b0;
    chk("t5_level_before_rst", 32'(bus.level_o_r), 32'd2);
    chk("t5_txd_bit3",         32'(bus.txd_o_r),   32'(8'h11 >> 3) & 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_txd",   32'(bus.txd_o_r),   32'd1);
    chk("t5_rst_level", 32'(bus.level_o_r), 32'd0);
    chk("t5_rst_sta",   32'(bus.sta_o_r),   32'h2);
    tick();
    tick();
    rst_n = 1'b1;
    hold_idle("t5_no_frames_after_rst", 300);
    push(8'h81);
    wait_low("t5_start_after_rst", 4);
    expect_frame("t5_frame_div_reset", 8'h81, 16, -1, -1, 16'd0);
    tick();

`ifdef JLC3_UART_TX_PARITY_EN
    // Parity: 0x07 has three ones
    bus.par_odd_i_w = 1'b0;
    push(8'h07);
    wait_low("t6_start_even", 4);
    expect_frame("t6_frame_even", 8'h07, 16, 1, -1, 16'd0);
    tick();
    bus.par_odd_i_w = 1'b1;
    push(8'h07);
    wait_low("t6_start_odd", 4);
    expect_frame("t6_frame_odd", 8'h07, 16, 0, -1, 16'd0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/jlc3_uart_tx.md
Name: jlc3_uart_tx

Overview:
Parametrised, buffered UART transmitter for the jlc3 SoC.
- Replaces the single-character send path between the memory controller's UART register and the TX pin.
- A FIFO decouples CPU store bursts from the serial line.
- Adds a run-time baud divider, overflow detection and configurable frame format.
- The memory controller pushes characters; the block serialises them LSB-first on txd_o_r.

Parameters:
DATA_W, 8, data bits per frame (5..9)
FIFO_DEPTH, 8, FIFO entries, power of 2, >=2
CLK_DIV, 16, reset value of baud divider (clocks per bit), >=2
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
clk_i_w  in  1  clock
rst_i_w  in  1  reset, asynchronous, active-low
en_i_w  in  1  global enable; low = no new frame starts
send_i_w  in  1  push strobe, one char per high cycle
schar_i_w  in  DATA_W  character to push
div_wr_i_w  in  1  load baud divider strobe
div_i_w  in  16  new divider value
clr_i_w  in  1  clear sticky overflow flag
sta_o_r  out  2  [0]=FIFO full, [1]=line idle (FIFO empty and FSM IDLE)
level_o_r  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
ovf_o_r  out  1  sticky: push attempted while full
txd_o_r  out  1  serial output, idle high

Behaviour:
- Reset (async, rst_i_w low) values:
  - txd_o_r=1, sta_o_r=2'b10, level_o_r=0, ovf_o_r=0.
  - Divider=CLK_DIV, FSM=IDLE, FIFO pointers 0.
  - Reset mid-frame aborts the frame immediately: txd high, FIFO contents discarded.
- Push:
  - Accepted iff send_i_w=1 and FIFO not full at the start of the cycle.
  - A pop in the same cycle does not make room.
  - Rejected push sets ovf_o_r=1 and drops the data.
  - ovf_o_r clears on clr_i_w=1. If clr and a rejected push coincide, set wins.
- level_o_r updates the cycle after push/pop. Simultaneous push+pop leaves level unchanged.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer MSB.
- Divider:
  - div_wr_i_w loads div_i_w into a shadow register.
  - Values 0 and 1 are clamped to 2.
  - The shadow is copied to the active divider only on entry to START, so a frame never changes rate mid-way.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: if en_i_w=1 and FIFO non-empty, pop head into shift register and go to START. txd=0 from the next cycle.
  - A char pushed into an empty FIFO is popped no earlier than the cycle after the push.
  - Bit timer runs 0..div-1 and restarts at each state entry; each bit lasts exactly div clocks.
  - START (txd=0, 1 bit) -> DATA.
  - DATA: shifts LSB-first for DATA_W bits, using a bit counter.
  - STOP: STOP_BITS bits, txd=1.
  - At the end of STOP: if en_i_w=1 and FIFO non-empty, pop and go directly to START (no idle gap); else IDLE.
  - en_i_w low mid-frame: the current frame completes; no new frame starts.
- Frame length is (1+DATA_W+STOP_BITS)*div clocks; with parity, (2+DATA_W+STOP_BITS)*div.
- sta_o_r is registered: [1] goes high the cycle after the FSM returns to IDLE with the FIFO empty.

Optional Feature:
- Macro: JLC3_UART_TX_PARITY_EN.
- Defined:
  - Adds PARITY state between DATA and STOP, sending the even parity bit of the character (XOR of data bits).
  - Adds input par_odd_i_w: 1 selects odd parity.
- Undefined: no PARITY state, no par_odd_i_w port, DATA goes straight to STOP.

Decomposition:
- Shared package/def.v holds:
  - FSM state encodings: UART_TX_IDLE, UART_TX_START, UART_TX_DATA, UART_TX_PARITY, UART_TX_STOP.
  - Status bit indices UART_STA_FULL=0, UART_STA_IDLE=1.
  - Divider minimum constant 2.
- One natural sub-module: sync_fifo, parametrised by width and depth, with push/pop/full/empty/level.
- Divider, bit timer and shift FSM stay in jlc3_uart_tx.

Test Plan:
- Reset, div=16, push 8'h55 once -> txd low 16 clks, then 1,0,1,0,1,0,1,0 at 16 clks each, then high; frame = 160 clks; sta_o_r returns to 2'b10.
- Push 3 chars back-to-back (8'h41,8'h42,8'h43) -> three contiguous frames with no idle gap, 480 clks total; level 3->2->1->0 at each pop.
- Push 10 chars at DEPTH=8 with line stalled (en_i_w=0) -> level=8, sta_o_r[0]=1, ovf_o_r=1, chars 9 and 10 never sent; clr_i_w clears ovf_o_r.
- Mid-frame div_wr with div=4 -> current frame keeps 16 clks/bit; next frame 4 clks/bit; div_i_w=0 gives 2 clks/bit.
- Assert rst_i_w low at bit 3 of a frame with 2 chars queued -> txd=1 immediately, level=0, no further frames after release.
- With JLC3_UART_TX_PARITY_EN, char 8'h07, par_odd_i_w=0 -> parity bit 1; with par_odd_i_w=1 -> parity bit 0; frame = 176 clks at div 16.
